// File: rtl/pad_stream_rx.sv
// pad_stream_rx: pad-side receive stage for the 8-bit input stream.
// Registers the input pins and buffers the beats in a small circular FIFO.
// Drives a registered ready back to the pad, keeping SKID free slots for
// beats that are still in flight after ready falls.
//
// Ports:
//   wb_clk_i     system clock, rising edge
//   wb_rst_ni    asynchronous active-low reset
//   pad_valid_i  valid level from the input pin
//   pad_last_i   last-beat flag from the input pin
//   pad_data_i   data from the input pins
//   pad_ready_o  registered ready to the output pin
//   m_valid_o    stream valid towards the core (FIFO not empty)
//   m_ready_i    stream ready from the core
//   m_data_o     stream data (FIFO head)
//   m_last_o     stream last (FIFO head)
//   level_o      current FIFO occupancy
//   overflow_o   sticky flag: a beat was dropped (cleared only by reset)
//
// Build option: define PAD_STREAM_RX_BITREV_EN to bit-reverse the pin data
// before the input register (for boards with MSB-first pin order).
module pad_stream_rx #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned SKID   = 2
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_ni,
    input  logic                       pad_valid_i,
    input  logic                       pad_last_i,
    input  logic [DATA_W-1:0]          pad_data_i,
    output logic                       pad_ready_o,
    output logic                       m_valid_o,
    input  logic                       m_ready_i,
    output logic [DATA_W-1:0]          m_data_o,
    output logic                       m_last_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       overflow_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    // Input register
    logic              rv_q;
    logic              rl_q;
    logic [DATA_W-1:0] rd_q;
    logic [DATA_W-1:0] pad_data_in;

    // FIFO storage and pointers (one extra wrap bit)
    logic [DEPTH-1:0][DATA_W-1:0] data_mem_q;
    logic [DEPTH-1:0]             last_mem_q;
    logic [PW-1:0]                wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]                rd_ptr_q, rd_ptr_d;
    logic                         ready_q, ready_d;
    logic                         overflow_q, overflow_d;

    logic [PW-1:0] level;
    logic [PW-1:0] level_next;
    logic          full;
    logic          empty;
    logic          pop;
    logic          push_ok;
    logic          drop;
    logic [AW-1:0] head_idx;

`ifdef PAD_STREAM_RX_BITREV_EN
    // Pin order is MSB-first on the board: reverse before registering
    always_comb begin
        pad_data_in = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            pad_data_in[i] = pad_data_i[DATA_W-1-i];
        end
    end
`else
    assign pad_data_in = pad_data_i;
`endif

    // Occupancy, push/pop qualification and next-state
    always_comb begin
        level      = wr_ptr_q - rd_ptr_q;
        full       = (level == PW'(DEPTH));
        empty      = (level == '0);
        pop        = !empty && m_ready_i;
        // A pop while full frees the slot this cycle's push uses
        push_ok    = rv_q && (!full || pop);
        drop       = rv_q && full && !pop;
        wr_ptr_d   = wr_ptr_q + PW'(push_ok);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        level_next = level + PW'(push_ok) - PW'(pop);
        ready_d    = (PW'(DEPTH) - level_next) > PW'(SKID);
        overflow_d = overflow_q || drop;
    end

    // When empty, show the last popped entry so the outputs hold their value
    assign head_idx = rd_ptr_q[AW-1:0] - AW'(empty);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            rv_q       <= 1'b0;
            rl_q       <= 1'b0;
            rd_q       <= '0;
            data_mem_q <= '0;
            last_mem_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ready_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            rv_q       <= pad_valid_i;
            rl_q       <= pad_last_i;
            rd_q       <= pad_data_in;
            if (push_ok) begin
                data_mem_q[wr_ptr_q[AW-1:0]] <= rd_q;
                last_mem_q[wr_ptr_q[AW-1:0]] <= rl_q;
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ready_q    <= ready_d;
            overflow_q <= overflow_d;
        end
    end

    assign pad_ready_o = ready_q;
    assign m_valid_o   = !empty;
    assign m_data_o    = data_mem_q[head_idx];
    assign m_last_o    = last_mem_q[head_idx];
    assign level_o     = level;
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_pad_stream_rx.sv
// Scoreboard bench for pad_stream_rx: the stimulus pushes expected beats,
// a negedge monitor pops and compares whenever a beat leaves the FIFO.
module tb_pad_stream_rx;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned SKID   = 2;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pad_valid_i;
    logic       pad_last_i;
    logic [7:0] pad_data_i;
    logic       pad_ready_o;
    logic       m_valid_o;
    logic       m_ready_i;
    logic [7:0] m_data_o;
    logic       m_last_o;
    logic [3:0] level_o;
    logic       overflow_o;

    int    checks = 0;
    int    errors = 0;
    int    pops   = 0;
    beat_t exp_q[$];
    beat_t mon_e;

    pad_stream_rx #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SKID(SKID)) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .pad_valid_i (pad_valid_i),
        .pad_last_i  (pad_last_i),
        .pad_data_i  (pad_data_i),
        .pad_ready_o (pad_ready_o),
        .m_valid_o   (m_valid_o),
        .m_ready_i   (m_ready_i),
        .m_data_o    (m_data_o),
        .m_last_o    (m_last_o),
        .level_o     (level_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] xform(input logic [7:0] d);
`ifdef PAD_STREAM_RX_BITREV_EN
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = d[7-i];
        return r;
`else
        return d;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pins set just after an edge, held until just after the next edge
    task automatic drive(input logic v, input logic l, input logic [7:0] d,
                         input logic r, input logic exp);
        beat_t b;
        pad_valid_i = v;
        pad_last_i  = l;
        pad_data_i  = d;
        m_ready_i   = r;
        b.last = l;
        b.data = xform(d);
        if (v && exp) exp_q.push_back(b);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    // Reset pulse issued mid-cycle; outputs must clear without a clock edge
    task automatic pulse_reset(input string name);
        pad_valid_i = 1'b0;
        m_ready_i   = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check({name, "_valid"}, m_valid_o, 0);
        check({name, "_ready"}, pad_ready_o, 0);
        check({name, "_level"}, level_o, 0);
        check({name, "_ovf"}, overflow_o, 0);
        exp_q.delete();
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check({name, "_ready_rise"}, pad_ready_o, 1);
    endtask

    // Monitor: a beat leaves when valid & ready are seen before the edge
    always @(negedge clk) begin
        if (rst_n && m_valid_o && m_ready_i) begin
            pops++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got %0h expected none", m_data_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("beat_data", m_data_o, mon_e.data);
                check("beat_last", m_last_o, mon_e.last);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   sent;
        int   max_lvl;
        int   p0;
        logic rprev, rnow, v, saw_low;

        rst_n       = 1'b0;
        pad_valid_i = 1'b0;
        pad_last_i  = 1'b0;
        pad_data_i  = 8'h00;
        m_ready_i   = 1'b0;
        #12;
        check("rst_ready", pad_ready_o, 0);
        check("rst_valid", m_valid_o, 0);
        check("rst_data", m_data_o, 0);
        check("rst_last", m_last_o, 0);
        check("rst_level", level_o, 0);
        check("rst_ovf", overflow_o, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", pad_ready_o, 1);

        // Pass-through with two-cycle pin-to-output latency
        drive(1'b1, 1'b0, 8'h01, 1'b1, 1'b1);
        check("pt_lat_edge1", m_valid_o, 0);
        drive(1'b1, 1'b0, 8'h02, 1'b1, 1'b1);
        check("pt_lat_edge2", m_valid_o, 1);
        check("pt_first_data", m_data_o, xform(8'h01));
        drive(1'b1, 1'b0, 8'h03, 1'b1, 1'b1);
        check("pt_level", level_o <= 4'd1, 1);
        drive(1'b1, 1'b1, 8'h04, 1'b1, 1'b1);
        check("pt_level", level_o <= 4'd1, 1);
        drain("pt_drain");
        check("pt_empty_valid", m_valid_o, 0);
        check("pt_hold_data", m_data_o, xform(8'h04));
        check("pt_hold_last", m_last_o, 1);
        check("pt_ovf", overflow_o, 0);

        // Backpressure: source stops two cycles after seeing ready low
        sent    = 0;
        max_lvl = 0;
        saw_low = 1'b0;
        rprev   = pad_ready_o;
        for (int cyc = 0; cyc < 80; cyc++) begin
            if (sent == 12 && exp_q.size() == 0) break;
            rnow = pad_ready_o;
            v    = rprev && (sent < 12);
            drive(v, sent == 11, 8'h10 + 8'(sent), cyc >= 20, 1'b1);
            if (v) sent++;
            rprev = rnow;
            if (!pad_ready_o) saw_low = 1'b1;
            if (int'(level_o) > max_lvl) max_lvl = int'(level_o);
            check("bp_ovf", overflow_o, 0);
            check("bp_ready_rule", pad_ready_o, (int'(DEPTH) - int'(level_o)) > int'(SKID));
        end
        check("bp_saw_ready_low", saw_low, 1);
        check("bp_max_level", max_lvl, 8);
        check("bp_sent", sent, 12);
        check("bp_drained", exp_q.size(), 0);

        // Overflow: valid ignores ready; beats 9 and 10 are dropped
        for (int k = 1; k <= 10; k++)
            drive(1'b1, k == 8, 8'h40 + 8'(k), 1'b0, k <= 8);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("ovf_level", level_o, 8);
        check("ovf_flag", overflow_o, 1);
        drain("ovf_drain");
        check("ovf_sticky", overflow_o, 1);
        pulse_reset("ovf_rst");

        // Full with simultaneous push and pop across pointer wrap
        for (int k = 1; k <= 20; k++) begin
            drive(1'b1, k == 20, 8'(k), k >= 10, 1'b1);
            if (k >= 9) check("full_level", level_o, 8);
        end
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("full_level_last", level_o, 8);
        check("full_ovf", overflow_o, 0);
        drain("full_drain");

        // Reset mid-packet with three beats buffered
        for (int k = 1; k <= 3; k++)
            drive(1'b1, 1'b0, 8'h60 + 8'(k), 1'b0, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("mid_level", level_o, 3);
        pulse_reset("mid_rst");
        p0 = pops;
        drive(1'b1, 1'b1, 8'hA5, 1'b1, 1'b1);
        drain("mid_drain");
        repeat (3) drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("mid_single_beat", pops - p0, 1);

        // Data orientation (straight or bit-reversed build)
        drive(1'b1, 1'b0, 8'h01, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 8'h3C, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
`ifdef PAD_STREAM_RX_BITREV_EN
        check("rev_01", m_data_o, 8'h80);
`else
        check("rev_01", m_data_o, 8'h01);
`endif
        drain("rev_drain");
        check("rev_3c", m_data_o, 8'h3C);

        check("final_queue", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
